// File: rtl/dram_cmd_pkg.sv
// Shared types and default timing for the DRAM command issuer: FSM state encoding,
// command-type enum and a small helper for sizing the spacing counter.
package dram_cmd_pkg;

   localparam int DEF_T_CL   = 17;
   localparam int DEF_T_RCD  = 17;
   localparam int DEF_T_RP   = 17;
   localparam int DEF_T_RFC  = 347;
   localparam int DEF_T_REFI = 7800;
   localparam int DEF_ROW_W  = 16;
   localparam int DEF_COL_W  = 10;

   localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
   localparam logic [2:0] ST_ACT_WAIT_ENC = 3'd1;
   localparam logic [2:0] ST_OPEN_ENC     = 3'd2;
   localparam logic [2:0] ST_CAS_WAIT_ENC = 3'd3;
   localparam logic [2:0] ST_PRE_WAIT_ENC = 3'd4;
   localparam logic [2:0] ST_REF_WAIT_ENC = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE     = ST_IDLE_ENC,
      ST_ACT_WAIT = ST_ACT_WAIT_ENC,
      ST_OPEN     = ST_OPEN_ENC,
      ST_CAS_WAIT = ST_CAS_WAIT_ENC,
      ST_PRE_WAIT = ST_PRE_WAIT_ENC,
      ST_REF_WAIT = ST_REF_WAIT_ENC
   } state_e;

   typedef enum logic [2:0] {
      CMD_NOP,
      CMD_ACT,
      CMD_RD,
      CMD_WR,
      CMD_RDA,
      CMD_WRA,
      CMD_PR,
      CMD_REF
   } cmd_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dram_timing_counter.sv
// Loadable saturating down-counter; flag_o is high while the count equals FLAG_AT.
// Used for command spacing (flag at 0) and for the refresh interval (flag at 1).
module dram_timing_counter #(
   parameter int WIDTH   = 8,
   parameter int RST_VAL = 0,
   parameter int FLAG_AT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic             flag_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= WIDTH'(RST_VAL);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign flag_o = (cnt_q == WIDTH'(FLAG_AT));

endmodule

// File: rtl/dram_cmd_issuer.sv
// Single-bank DRAM command issuer: open-page row tracking, tRCD/tCL/tRP/tRFC spacing, tREFI refresh.
// Define CLOSED_PAGE_EN to issue RDA/WRA with auto-precharge and return to IDLE after every access.
module dram_cmd_issuer
   import dram_cmd_pkg::*;
#(
   parameter int T_CL   = DEF_T_CL,
   parameter int T_RCD  = DEF_T_RCD,
   parameter int T_RP   = DEF_T_RP,
   parameter int T_RFC  = DEF_T_RFC,
   parameter int T_REFI = DEF_T_REFI,
   parameter int ROW_W  = DEF_ROW_W,
   parameter int COL_W  = DEF_COL_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [ROW_W-1:0] req_row,
   input  logic [COL_W-1:0] req_col,
   output logic             cmd_act,
   output logic             cmd_rd,
   output logic             cmd_wr,
   output logic             cmd_rda,
   output logic             cmd_wra,
   output logic             cmd_pr,
   output logic             cmd_ref,
   output logic [ROW_W-1:0] cmd_row,
   output logic [COL_W-1:0] cmd_col,
   output logic             row_open,
   output logic [ROW_W-1:0] open_row,
   output logic [2:0]       state
);

`ifdef CLOSED_PAGE_EN
   localparam bit CLOSED_PAGE = 1'b1;
`else
   localparam bit CLOSED_PAGE = 1'b0;
`endif

   localparam int CNT_W  = $clog2(max2(max2(T_CL + T_RP, T_RCD), max2(T_RP, T_RFC)) + 1);
   localparam int REFI_W = $clog2(T_REFI + 1);

   localparam logic [CNT_W-1:0] ACT_LOAD = CNT_W'(T_RCD - 1);
   localparam logic [CNT_W-1:0] PR_LOAD  = CNT_W'(T_RP - 1);
   localparam logic [CNT_W-1:0] REF_LOAD = CNT_W'(T_RFC - 1);
   // With auto-precharge the CAS wait also covers the implicit precharge.
   localparam logic [CNT_W-1:0] CAS_LOAD = CLOSED_PAGE ? CNT_W'(T_CL + T_RP - 1) : CNT_W'(T_CL - 1);

   state_e           state_q, state_d;
   cmd_e             cmd_d;
   logic [ROW_W-1:0] cmd_row_q, cmd_row_d;
   logic [COL_W-1:0] cmd_col_q, cmd_col_d;
   logic             cmd_act_q, cmd_rd_q, cmd_wr_q, cmd_pr_q, cmd_ref_q;
`ifdef CLOSED_PAGE_EN
   logic             cmd_rda_q, cmd_wra_q;
`endif
   logic             row_open_q, row_open_d;
   logic [ROW_W-1:0] open_row_q, open_row_d;
   logic             req_ready_q, req_ready_d;
   logic             lat_valid_q, lat_valid_d;
   logic             lat_write_q, lat_write_d;
   logic [ROW_W-1:0] lat_row_q, lat_row_d;
   logic [COL_W-1:0] lat_col_q, lat_col_d;
   logic             ref_pending_q, ref_pending_d;
   logic             ref_clr;
   logic             refi_fire;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_zero;
   logic             handshake;

   assign handshake = req_valid & req_ready_q;

   dram_timing_counter #(
      .WIDTH   (CNT_W),
      .RST_VAL (0),
      .FLAG_AT (0)
   ) u_cmd_tmr (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .flag_o     (tmr_zero)
   );

   dram_timing_counter #(
      .WIDTH   (REFI_W),
      .RST_VAL (T_REFI),
      .FLAG_AT (1)
   ) u_refi_tmr (
      .clk        (clk),
      .rst        (rst),
      .load_i     (refi_fire),
      .load_val_i (REFI_W'(T_REFI)),
      .flag_o     (refi_fire)
   );

   function automatic cmd_e cas_cmd(input logic wr);
      if (CLOSED_PAGE) begin
         return wr ? CMD_WRA : CMD_RDA;
      end
      return wr ? CMD_WR : CMD_RD;
   endfunction

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      cmd_d       = CMD_NOP;
      cmd_row_d   = '0;
      cmd_col_d   = '0;
      row_open_d  = row_open_q;
      open_row_d  = open_row_q;
      lat_valid_d = lat_valid_q;
      lat_write_d = lat_write_q;
      lat_row_d   = lat_row_q;
      lat_col_d   = lat_col_q;
      tmr_load    = 1'b0;
      tmr_val     = '0;
      ref_clr     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (ref_pending_q) begin
               cmd_d    = CMD_REF;
               ref_clr  = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = REF_LOAD;
               state_d  = ST_REF_WAIT;
            end else if (lat_valid_q || handshake) begin
               // A request parked behind a refresh is opened before new traffic is accepted.
               if (!lat_valid_q) begin
                  lat_valid_d = 1'b1;
                  lat_write_d = req_write;
                  lat_row_d   = req_row;
                  lat_col_d   = req_col;
               end
               cmd_d      = CMD_ACT;
               cmd_row_d  = lat_valid_q ? lat_row_q : req_row;
               row_open_d = 1'b1;
               open_row_d = cmd_row_d;
               tmr_load   = 1'b1;
               tmr_val    = ACT_LOAD;
               state_d    = ST_ACT_WAIT;
            end
         end
         ST_ACT_WAIT: begin
            if (tmr_zero) begin
               cmd_d       = cas_cmd(lat_write_q);
               cmd_col_d   = lat_col_q;
               lat_valid_d = 1'b0;
               if (CLOSED_PAGE) row_open_d = 1'b0;
               tmr_load    = 1'b1;
               tmr_val     = CAS_LOAD;
               state_d     = ST_CAS_WAIT;
            end
         end
         ST_OPEN: begin
            if (ref_pending_q) begin
               cmd_d      = CMD_PR;
               row_open_d = 1'b0;
               tmr_load   = 1'b1;
               tmr_val    = PR_LOAD;
               state_d    = ST_PRE_WAIT;
            end else if (handshake) begin
               if (req_row == open_row_q) begin
                  cmd_d     = cas_cmd(req_write);
                  cmd_col_d = req_col;
                  if (CLOSED_PAGE) row_open_d = 1'b0;
                  tmr_load  = 1'b1;
                  tmr_val   = CAS_LOAD;
                  state_d   = ST_CAS_WAIT;
               end else begin
                  lat_valid_d = 1'b1;
                  lat_write_d = req_write;
                  lat_row_d   = req_row;
                  lat_col_d   = req_col;
                  cmd_d       = CMD_PR;
                  row_open_d  = 1'b0;
                  tmr_load    = 1'b1;
                  tmr_val     = PR_LOAD;
                  state_d     = ST_PRE_WAIT;
               end
            end
         end
         ST_PRE_WAIT: begin
            if (tmr_zero) begin
               if (ref_pending_q) begin
                  cmd_d    = CMD_REF;
                  ref_clr  = 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = REF_LOAD;
                  state_d  = ST_REF_WAIT;
               end else if (lat_valid_q) begin
                  cmd_d      = CMD_ACT;
                  cmd_row_d  = lat_row_q;
                  row_open_d = 1'b1;
                  open_row_d = lat_row_q;
                  tmr_load   = 1'b1;
                  tmr_val    = ACT_LOAD;
                  state_d    = ST_ACT_WAIT;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_CAS_WAIT: begin
            if (tmr_zero) state_d = CLOSED_PAGE ? ST_IDLE : ST_OPEN;
         end
         ST_REF_WAIT: begin
            if (tmr_zero) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A fresh tREFI expiry wins over a clear issued in the same cycle.
      ref_pending_d = refi_fire | (ref_pending_q & ~ref_clr);
      req_ready_d   = ((state_d == ST_IDLE) || (state_d == ST_OPEN)) && !lat_valid_d && !ref_pending_d;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cmd_act_q     <= 1'b0;
         cmd_rd_q      <= 1'b0;
         cmd_wr_q      <= 1'b0;
         cmd_pr_q      <= 1'b0;
         cmd_ref_q     <= 1'b0;
`ifdef CLOSED_PAGE_EN
         cmd_rda_q     <= 1'b0;
         cmd_wra_q     <= 1'b0;
`endif
         cmd_row_q     <= '0;
         cmd_col_q     <= '0;
         row_open_q    <= 1'b0;
         open_row_q    <= '0;
         req_ready_q   <= 1'b0;
         lat_valid_q   <= 1'b0;
         lat_write_q   <= 1'b0;
         lat_row_q     <= '0;
         lat_col_q     <= '0;
         ref_pending_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_act_q     <= (cmd_d == CMD_ACT);
         cmd_rd_q      <= (cmd_d == CMD_RD);
         cmd_wr_q      <= (cmd_d == CMD_WR);
         cmd_pr_q      <= (cmd_d == CMD_PR);
         cmd_ref_q     <= (cmd_d == CMD_REF);
`ifdef CLOSED_PAGE_EN
         cmd_rda_q     <= (cmd_d == CMD_RDA);
         cmd_wra_q     <= (cmd_d == CMD_WRA);
`endif
         cmd_row_q     <= cmd_row_d;
         cmd_col_q     <= cmd_col_d;
         row_open_q    <= row_open_d;
         open_row_q    <= open_row_d;
         req_ready_q   <= req_ready_d;
         lat_valid_q   <= lat_valid_d;
         lat_write_q   <= lat_write_d;
         lat_row_q     <= lat_row_d;
         lat_col_q     <= lat_col_d;
         ref_pending_q <= ref_pending_d;
      end
   end

   assign cmd_act   = cmd_act_q;
   assign cmd_rd    = cmd_rd_q;
   assign cmd_wr    = cmd_wr_q;
   assign cmd_pr    = cmd_pr_q;
   assign cmd_ref   = cmd_ref_q;
`ifdef CLOSED_PAGE_EN
   assign cmd_rda   = cmd_rda_q;
   assign cmd_wra   = cmd_wra_q;
`else
   assign cmd_rda   = 1'b0;
   assign cmd_wra   = 1'b0;
`endif
   assign cmd_row   = cmd_row_q;
   assign cmd_col   = cmd_col_q;
   assign row_open  = row_open_q;
   assign open_row  = open_row_q;
   assign req_ready = req_ready_q;
   assign state     = state_q;

endmodule

// File: tb/tb_dram_cmd_issuer.sv
// Directed bench for dram_cmd_issuer with short timings (tCL=2 tRCD=3 tRP=2 tRFC=5 tREFI=40).
// Cycle 0 is the first cycle after reset release; outputs are sampled 1 time unit after each edge.
module tb_dram_cmd_issuer;
   import dram_cmd_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [15:0] req_row = '0;
   logic [9:0]  req_col = '0;
   logic        cmd_act, cmd_rd, cmd_wr, cmd_rda, cmd_wra, cmd_pr, cmd_ref;
   logic [15:0] cmd_row;
   logic [9:0]  cmd_col;
   logic        row_open;
   logic [15:0] open_row;
   logic [2:0]  state;

   int   n_pass   = 0;
   int   n_checks = 0;
   int   cyc      = 0;
   logic pr_seen  = 1'b0;
   logic cas_seen = 1'b0;
   logic multi_cmd = 1'b0;

   dram_cmd_issuer #(
      .T_CL   (2),
      .T_RCD  (3),
      .T_RP   (2),
      .T_RFC  (5),
      .T_REFI (40),
      .ROW_W  (16),
      .COL_W  (10)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_row   (req_row),
      .req_col   (req_col),
      .cmd_act   (cmd_act),
      .cmd_rd    (cmd_rd),
      .cmd_wr    (cmd_wr),
      .cmd_rda   (cmd_rda),
      .cmd_wra   (cmd_wra),
      .cmd_pr    (cmd_pr),
      .cmd_ref   (cmd_ref),
      .cmd_row   (cmd_row),
      .cmd_col   (cmd_col),
      .row_open  (row_open),
      .open_row  (open_row),
      .state     (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (cmd_pr) pr_seen = 1'b1;
      if (cmd_rd | cmd_wr | cmd_rda | cmd_wra) cas_seen = 1'b1;
      if ($countones({cmd_act, cmd_rd, cmd_wr, cmd_rda, cmd_wra, cmd_pr, cmd_ref}) > 1) multi_cmd = 1'b1;
   endtask

   task automatic tick_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic drive(input logic v, input logic w, input logic [15:0] row, input logic [9:0] col);
      req_valid = v;
      req_write = w;
      req_row   = row;
      req_col   = col;
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;

      check("rst_state", 32'(state), 32'(ST_IDLE));
      check("rst_ready", 32'(req_ready), 0);
      check("rst_row_open", 32'(row_open), 0);
      check("rst_open_row", 32'(open_row), 0);
      check("rst_cmd_row", 32'(cmd_row), 0);

`ifdef CLOSED_PAGE_EN
      tick_to(10);
      check("cp_ready_c10", 32'(req_ready), 1);
      drive(1'b1, 1'b0, 16'h0012, 10'h005);
      tick();
      drive(1'b0, 1'b0, 16'h0, 10'h0);
      check("cp_act1", 32'(cmd_act), 1);
      check("cp_act1_row", 32'(cmd_row), 32'h12);
      tick_to(14);
      check("cp_rda1", 32'(cmd_rda), 1);
      check("cp_rda1_col", 32'(cmd_col), 32'h5);
      check("cp_row_closed", 32'(row_open), 0);
      tick_to(18);
      check("cp_idle", 32'(state), 32'(ST_IDLE));
      check("cp_ready_c18", 32'(req_ready), 1);
      drive(1'b1, 1'b0, 16'h0012, 10'h006);
      tick();
      drive(1'b0, 1'b0, 16'h0, 10'h0);
      check("cp_act2", 32'(cmd_act), 1);
      check("cp_act2_row", 32'(cmd_row), 32'h12);
      tick_to(22);
      check("cp_rda2", 32'(cmd_rda), 1);
      check("cp_rda2_col", 32'(cmd_col), 32'h6);
      tick_to(30);
      check("cp_no_pr", 32'(pr_seen), 0);
`else
      // Read to a closed bank.
      tick_to(10);
      check("t1_ready_c10", 32'(req_ready), 1);
      drive(1'b1, 1'b0, 16'h0012, 10'h005);
      tick();
      drive(1'b0, 1'b0, 16'h0, 10'h0);
      check("t1_act", 32'(cmd_act), 1);
      check("t1_act_row", 32'(cmd_row), 32'h12);
      check("t1_row_open", 32'(row_open), 1);
      check("t1_open_row", 32'(open_row), 32'h12);
      check("t1_ready_low", 32'(req_ready), 0);
      check("t1_state", 32'(state), 32'(ST_ACT_WAIT));
      tick_to(13);
      check("t1_no_early_rd", 32'(cmd_rd), 0);
      tick();
      check("t1_rd", 32'(cmd_rd), 1);
      check("t1_rd_col", 32'(cmd_col), 32'h5);
      check("t1_rd_row_zero", 32'(cmd_row), 0);
      check("t1_rda_tied", 32'(cmd_rda), 0);
      tick();
      check("t1_ready_c15", 32'(req_ready), 0);
      tick();
      check("t1_ready_c16", 32'(req_ready), 1);
      check("t1_state_open", 32'(state), 32'(ST_OPEN));

      // Row hit.
      drive(1'b1, 1'b0, 16'h0012, 10'h007);
      tick();
      drive(1'b0, 1'b0, 16'h0, 10'h0);
      check("t2_rd", 32'(cmd_rd), 1);
      check("t2_rd_col", 32'(cmd_col), 32'h7);
      check("t2_no_act", 32'(cmd_act), 0);
      check("t2_no_pr", 32'(cmd_pr), 0);
      tick_to(19);
      check("t2_ready_c19", 32'(req_ready), 1);

      // Row miss write to 0x34.
      drive(1'b1, 1'b1, 16'h0034, 10'h009);
      tick();
      drive(1'b0, 1'b0, 16'h0, 10'h0);
      check("t3_pr", 32'(cmd_pr), 1);
      check("t3_row_closed", 32'(row_open), 0);
      tick_to(22);
      check("t3_act", 32'(cmd_act), 1);
      check("t3_act_row", 32'(cmd_row), 32'h34);
      tick_to(25);
      check("t3_wr", 32'(cmd_wr), 1);
      check("t3_wr_col", 32'(cmd_col), 32'h9);
      check("t3_open_row", 32'(open_row), 32'h34);
      check("t3_row_open", 32'(row_open), 1);
      tick_to(27);
      check("t3_ready_c27", 32'(req_ready), 1);

      // Refresh expiry with the bank open.
      tick_to(39);
      check("t4_ready_c39", 32'(req_ready), 1);
      tick();
      check("t4_ready_drop", 32'(req_ready), 0);
      tick();
      check("t4_pr", 32'(cmd_pr), 1);
      check("t4_row_closed", 32'(row_open), 0);
      tick_to(43);
      check("t4_ref", 32'(cmd_ref), 1);
      tick_to(47);
      check("t4_ref_wait", 32'(state), 32'(ST_REF_WAIT));
      tick();
      check("t4_idle", 32'(state), 32'(ST_IDLE));
      check("t4_ready_c48", 32'(req_ready), 1);

      // Reset during ACT_WAIT.
      drive(1'b1, 1'b0, 16'h0056, 10'h001);
      tick();
      drive(1'b0, 1'b0, 16'h0, 10'h0);
      check("t5_act", 32'(cmd_act), 1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_cmds_clear", 32'({cmd_act, cmd_rd, cmd_wr, cmd_pr, cmd_ref}), 0);
      check("t5_cmd_row", 32'(cmd_row), 0);
      check("t5_cmd_col", 32'(cmd_col), 0);
      check("t5_row_open", 32'(row_open), 0);
      check("t5_open_row", 32'(open_row), 0);
      check("t5_ready", 32'(req_ready), 0);
      check("t5_state", 32'(state), 32'(ST_IDLE));
      cyc = 0;
      cas_seen = 1'b0;
      tick_to(8);
      check("t5_no_cas", 32'(cas_seen), 0);

      // Refresh from IDLE racing a new request: refresh wins, request waits.
      tick_to(39);
      check("t6_ready_c39", 32'(req_ready), 1);
      tick();
      check("t6_ready_drop", 32'(req_ready), 0);
      drive(1'b1, 1'b0, 16'h0077, 10'h003);
      tick();
      check("t6_ref", 32'(cmd_ref), 1);
      check("t6_no_act", 32'(cmd_act), 0);
      tick_to(45);
      check("t6_ready_c45", 32'(req_ready), 0);
      tick();
      check("t6_ready_c46", 32'(req_ready), 1);
      tick();
      drive(1'b0, 1'b0, 16'h0, 10'h0);
      check("t6_act", 32'(cmd_act), 1);
      check("t6_act_row", 32'(cmd_row), 32'h77);
      tick_to(50);
      check("t6_rd", 32'(cmd_rd), 1);
      check("t6_rd_col", 32'(cmd_col), 32'h3);
`endif

      check("one_hot_cmds", 32'(multi_cmd), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
